// File: rtl/gfx_wbm_pkg.sv
// Shared constants and types for the GFX Wishbone read arbiter.
package gfx_wbm_pkg;

    // Wishbone B3 cycle type identifiers
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // Burst type extension: linear bursts only
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    // Byte select value seen on the bus while no burst has been granted
    localparam logic [3:0] SEL_RESET   = 4'hF;

    // Watchdog counter width; large enough for any legal TIMEOUT
    localparam int WD_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Cycle type for a given beat: single transfers are classic, bursts use
    // incrementing beats followed by an end-of-burst marker on the last beat.
    function automatic logic [2:0] cti_for_beat(input int unsigned beat,
                                                input int unsigned last);
        if (last == 0) begin
            return CTI_CLASSIC;
        end else if (beat < last) begin
            return CTI_INCR;
        end else begin
            return CTI_EOB;
        end
    endfunction

endpackage

// File: rtl/gfx_wbm_read_arb_arbiter.sv
// Round-robin arbiter: picks the first requester at or after the pointer,
// wrapping; the pointer moves to one past the winner when a grant is taken.
module gfx_rr_arbiter
    import gfx_wbm_pkg::*;
#(
    parameter int NUM_CH = 3,
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NUM_CH-1:0] req_i,
    input  logic              advance_i,
    output logic              any_o,
    output logic [NUM_CH-1:0] gnt_o,
    output logic [IDX_W-1:0]  idx_o
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W-1:0] cand;

    // ptr + k never exceeds 2*NUM_CH-2, so one conditional subtract wraps it
    function automatic logic [IDX_W-1:0] wrap_idx(input int v);
        if (v >= NUM_CH) begin
            return IDX_W'(v - NUM_CH);
        end else begin
            return IDX_W'(v);
        end
    endfunction

    // Priority search starting at the pointer
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = wrap_idx(int'(ptr_q) + k);
            if (!any_o && req_i[cand]) begin
                any_o = 1'b1;
                idx_o = cand;
            end
        end
        if (any_o) begin
            gnt_o[idx_o] = 1'b1;
        end
    end

    // Next pointer: one past the winner, only when a grant is actually taken
    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && any_o) begin
            ptr_d = (int'(idx_o) == NUM_CH - 1) ? '0 : idx_o + 1'b1;
        end
    end

    // Pointer register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/gfx_wbm_read_arb.sv
// Multi-channel Wishbone B3 read master: round-robin shares one bus port
// among NUM_CH requesters, runs linear incrementing bursts, aborts on bus
// error or ack watchdog expiry, and reports per-channel data/done/error.
module gfx_wbm_read_arb
    import gfx_wbm_pkg::*;
#(
    parameter int NUM_CH  = 3,
    parameter int BURST_W = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    output logic                      cyc_o,
    output logic                      stb_o,
    output logic [2:0]                cti_o,
    output logic [1:0]                bte_o,
    output logic                      we_o,
    output logic [31:0]               adr_o,
    output logic [3:0]                sel_o,
    input  logic                      ack_i,
    input  logic                      err_i,
    input  logic [31:0]               dat_i,
    output logic                      sint_o,
    input  logic [NUM_CH-1:0]         req_i,
    input  logic [NUM_CH*30-1:0]      adr_i,
    input  logic [NUM_CH*4-1:0]       sel_i,
    input  logic [NUM_CH*BURST_W-1:0] len_i,
    output logic [31:0]               dat_o,
    output logic [NUM_CH-1:0]         valid_o,
    output logic [NUM_CH-1:0]         done_o,
    output logic [NUM_CH-1:0]         err_o
);

    localparam int              IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

    state_e               state_q, state_d;
    logic [NUM_CH-1:0]    goh_q, goh_d;
    logic [29:0]          adr_q, adr_d;
    logic [3:0]           sel_q, sel_d;
    logic [BURST_W-1:0]   len_q, len_d;
    logic [BURST_W-1:0]   beat_q, beat_d;
    logic [WD_W-1:0]      wd_q, wd_d;
    logic                 cyc_q, cyc_d;
    logic [31:0]          dat_q, dat_d;
    logic [NUM_CH-1:0]    valid_q, valid_d;
    logic [NUM_CH-1:0]    done_q, done_d;
    logic [NUM_CH-1:0]    err_q, err_d;
    logic                 sint_q, sint_d;

    logic                 arb_any;
    logic [NUM_CH-1:0]    arb_gnt;
    logic [IDX_W-1:0]     arb_idx;
    logic [WD_W-1:0]      wd_inc;

    gfx_rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_i),
        .advance_i (state_q == ST_IDLE),
        .any_o     (arb_any),
        .gnt_o     (arb_gnt),
        .idx_o     (arb_idx)
    );

    assign wd_inc = wd_q + 1'b1;

    // Next-state logic: grant in IDLE, beat handling in BURST, one-cycle DONE
    always_comb begin
        state_d = state_q;
        goh_d   = goh_q;
        adr_d   = adr_q;
        sel_d   = sel_q;
        len_d   = len_q;
        beat_d  = beat_q;
        wd_d    = wd_q;
        cyc_d   = cyc_q;
        dat_d   = dat_q;
        valid_d = '0;
        done_d  = '0;
        err_d   = '0;
        sint_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    goh_d   = arb_gnt;
                    adr_d   = adr_i[int'(arb_idx)*30 +: 30];
                    sel_d   = sel_i[int'(arb_idx)*4 +: 4];
                    len_d   = len_i[int'(arb_idx)*BURST_W +: BURST_W];
                    beat_d  = '0;
                    wd_d    = '0;
                    cyc_d   = 1'b1;
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                if (ack_i && !err_i) begin
                    dat_d   = dat_i;
                    valid_d = goh_q;
                    adr_d   = adr_q + 30'd1;
                    beat_d  = beat_q + 1'b1;
                    wd_d    = '0;
                    if (beat_q == len_q) begin
                        cyc_d   = 1'b0;
                        done_d  = goh_q;
                        state_d = ST_DONE;
                    end
                end else if (err_i || wd_inc == WD_LIMIT) begin
                    // Bus error and watchdog expiry end the burst identically
                    cyc_d   = 1'b0;
                    done_d  = goh_q;
                    err_d   = goh_q;
                    sint_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    wd_d = wd_inc;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any burst in flight
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            goh_q   <= '0;
            adr_q   <= '0;
            sel_q   <= SEL_RESET;
            len_q   <= '0;
            beat_q  <= '0;
            wd_q    <= '0;
            cyc_q   <= 1'b0;
            dat_q   <= '0;
            valid_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
            sint_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            goh_q   <= goh_d;
            adr_q   <= adr_d;
            sel_q   <= sel_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            wd_q    <= wd_d;
            cyc_q   <= cyc_d;
            dat_q   <= dat_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
            sint_q  <= sint_d;
        end
    end

    // Cycle type follows the beat position of the active burst
    always_comb begin
        cti_o = CTI_CLASSIC;
        if (state_q == ST_BURST) begin
            cti_o = cti_for_beat(32'(beat_q), 32'(len_q));
        end
    end

    // A read-only master strobes for the whole cycle
    assign cyc_o   = cyc_q;
    assign stb_o   = cyc_q;
    assign we_o    = 1'b0;
    assign bte_o   = BTE_LINEAR;
    assign adr_o   = {adr_q, 2'b00};
    assign sel_o   = sel_q;
    assign dat_o   = dat_q;
    assign valid_o = valid_q;
    assign done_o  = done_q;
    assign err_o   = err_q;
    assign sint_o  = sint_q;

endmodule

// File: doc/gfx_wbm_read_arb.md
Name: gfx_wbm_read_arb

Overview:
Multi-channel Wishbone B3 read master for the GFX accelerator. It replaces the single-requester texture reader with one bus port shared by NUM_CH requesters (texture, blender, depth), using round-robin arbitration. It supports incrementing bursts up to 2^BURST_W beats, an ack watchdog, and per-channel error reporting. Read-only; sits between the GFX pipeline stages and the memory interconnect.

Parameters:
NUM_CH, 3, number of requesting channels (1..8)
BURST_W, 3, burst length field width; max burst = 2^BURST_W beats
TIMEOUT, 255, cycles without ack/err before a transfer is aborted (1..65535)

Ports:
clk_i  in  1  master clock
rst_i  in  1  synchronous active-high reset
cyc_o  out  1  Wishbone cycle
stb_o  out  1  Wishbone strobe
cti_o  out  3  cycle type id
bte_o  out  2  burst type extension, constant 2'b00 (linear)
we_o  out  1  constant 0
adr_o  out  32  byte address, bits [1:0] always 0
sel_o  out  4  byte select
ack_i  in  1  Wishbone ack
err_i  in  1  Wishbone error
dat_i  in  32  Wishbone read data
sint_o  out  1  one-cycle pulse on bus error or timeout
req_i  in  NUM_CH  per-channel request, level
adr_i  in  NUM_CH*30  per-channel start word address [31:2]
sel_i  in  NUM_CH*4  per-channel byte select
len_i  in  NUM_CH*BURST_W  per-channel beats minus 1
dat_o  out  32  registered read data, shared
valid_o  out  NUM_CH  one-hot, dat_o valid for that channel
done_o  out  NUM_CH  one-hot, one-cycle pulse at end of transfer
err_o  out  NUM_CH  one-hot, qualifies done_o as failed

Behaviour:
- Reset values: cyc_o/stb_o=0, cti_o=000, adr_o=0, sel_o=4'hF, sint_o=0, dat_o=0, valid_o/done_o/err_o=0. Round-robin pointer resets to channel 0. Reset mid-burst drops cyc_o at the next edge; the transfer is discarded with no done_o.
- FSM states: IDLE, BURST, DONE.
- IDLE: if any req_i is set, grant the first requesting channel at or after the pointer (wrapping). Latch adr, sel and len; set beat counter=0 and watchdog=0. Assert cyc_o/stb_o next cycle and go to BURST. Pointer = granted+1 mod NUM_CH.
- BURST, cti_o: 000 when len=0; otherwise 010 for beats < len and 111 for the final beat.
- BURST, on ack_i (err_i low):
  - Register dat_i into dat_o; valid_o[g]=1 next cycle (latency 1).
  - adr_o += 4, with the word address wrapping modulo 2^30. Beat counter +1. Watchdog cleared.
  - On the final beat: drop cyc_o/stb_o, pulse done_o[g] in the same cycle as the last valid_o, go to DONE.
- BURST, on err_i (wins over a simultaneous ack_i): drop cyc_o/stb_o next edge, no valid_o for that beat. Pulse done_o[g], err_o[g] and sint_o together. Go to DONE.
- BURST, neither ack nor err: watchdog +1. When watchdog reaches TIMEOUT, handle exactly as err_i.
- DONE: one cycle. req_i[g] is ignored here; the requester must drop req_i on seeing done_o. Return to IDLE. Back-to-back grants are therefore separated by 2 idle bus cycles.
- sel_o is held constant for all beats of a burst. we_o=0 and bte_o=00 always.
- Changes to adr_i/sel_i/len_i after grant have no effect until the next grant.

Decomposition:
- Package gfx_wbm_pkg: CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111, BTE_LINEAR=2'b00, state encoding for IDLE/BURST/DONE.
- Sub-module gfx_rr_arbiter (parameter NUM_CH): req vector + pointer -> one-hot grant + index, combinational, pointer register inside. Everything else stays in gfx_wbm_read_arb.

Test Plan:
1. Single read: req_i[0], adr=0x100>>2, len=0, sel=F, ack after 2 cycles -> adr_o=0x100, cti_o=000; dat_o=dat_i, valid_o=001 and done_o=001 one cycle after ack; cyc_o low.
2. Burst: ch1, adr=0x200, len=3, ack every cycle -> adr_o 0x200,0x204,0x208,0x20C; cti_o 010,010,010,111; 4 valid_o=010 pulses; done_o with the 4th.
3. Round-robin: all three req_i held, len=0 -> grants in order 0,1,2,0. After reset with only ch2 and ch0 requesting, order is 0,2.
4. Error: ch2 len=3, err_i together with ack_i on beat 2 -> only 1 valid_o; done_o=err_o=100 and sint_o pulse in the same cycle; cyc_o low next edge.
5. Timeout: TIMEOUT=8, no ack -> cyc_o high for exactly 8 cycles, then err_o/done_o/sint_o pulse.
6. Wrap and reset: adr=0xFFFFFFFC, len=1 -> second adr_o=0x00000000. Separately, rst_i asserted on beat 2 of 4 -> cyc_o=0 next edge, no done_o, and the next grant goes to channel 0.
